// File: rtl/tm_sch_pri_mem_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tm_sch_pri_mem_bank_pkg                                      |
// | Description : Shared widths and FSM encoding for the scheduler memory bank |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package tm_sch_pri_mem_bank_pkg;

  localparam int c_pio_w_def                 = 32;
  localparam int c_nch_def                   = 8;
  localparam int c_second_lvl_queue_id_nbits = 6;
  localparam int c_second_lvl_sch_id_nbits   = 4;

  // PIO addresses are byte addresses; memory words start at bit 2.
  localparam int c_word_lsb = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tm_sch_pri_mem_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tm_sch_pri_mem_bank_if                                       |
// | Description : PIO register bus and scheduler read channels of the bank     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface tm_sch_pri_mem_bank_if
  import tm_sch_pri_mem_bank_pkg::*;
#(
  parameter int NCH         = c_nch_def,
  parameter int WIDTH       = 2 * c_second_lvl_queue_id_nbits,
  parameter int DEPTH_NBITS = c_second_lvl_sch_id_nbits,
  parameter int PIO_W       = c_pio_w_def
);

  logic [PIO_W-1:0]           reg_addr;
  logic [PIO_W-1:0]           reg_din;
  logic                       reg_rd;
  logic                       reg_wr;
  logic [NCH-1:0]             reg_ms;
  logic [NCH-1:0]             app_rd;
  logic [NCH*DEPTH_NBITS-1:0] app_raddr;
  logic [NCH-1:0]             app_ack;
  logic [NCH*WIDTH-1:0]       app_rdata;
  logic                       mem_ack;
  logic [PIO_W-1:0]           mem_rdata;
  logic                       init_done;
  logic                       err_wr_during_init;

  modport master (
    output reg_addr, reg_din, reg_rd, reg_wr, reg_ms, app_rd, app_raddr,
    input  app_ack, app_rdata, mem_ack, mem_rdata, init_done, err_wr_during_init
  );

  modport slave (
    input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms, app_rd, app_raddr,
    output app_ack, app_rdata, mem_ack, mem_rdata, init_done, err_wr_during_init
  );

endinterface
`default_nettype wire

// File: rtl/tm_sch_pri_mem_bank_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tm_sch_pri_mem_chan                                          |
// | Description : One 1R1W control memory with forwarding, app/PIO read mux    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tm_sch_pri_mem_chan
  import tm_sch_pri_mem_bank_pkg::*;
#(
  parameter int WIDTH       = 2 * c_second_lvl_queue_id_nbits,
  parameter int DEPTH_NBITS = c_second_lvl_sch_id_nbits
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_init,
  input  logic                   i_we,
  input  logic [DEPTH_NBITS-1:0] i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_app_rd,
  input  logic [DEPTH_NBITS-1:0] i_app_raddr,
  output logic                   o_app_ack,
  output logic [WIDTH-1:0]       o_app_rdata,
  input  logic                   i_pio_set,
  input  logic [DEPTH_NBITS-1:0] i_pio_raddr,
  output logic                   o_pend,
  output logic                   o_pio_ack,
  output logic [WIDTH-1:0]       o_pio_rdata
);

  localparam int c_depth = 1 << DEPTH_NBITS;

  logic [WIDTH-1:0]       r_mem [c_depth];
  logic                   r_pend;
  logic [DEPTH_NBITS-1:0] r_pend_addr;
  logic                   r_app_ack;
  logic [WIDTH-1:0]       r_app_rdata;
  logic                   r_pio_ack;
  logic [WIDTH-1:0]       r_pio_rdata;

  logic                   w_svc;
  logic [DEPTH_NBITS-1:0] w_raddr;
  logic [WIDTH-1:0]       w_rword;

  // The single read port goes to the app whenever it asks; PIO only fills idle slots.
  assign w_svc   = r_pend & ~i_app_rd & ~i_init;
  assign w_raddr = i_app_rd ? i_app_raddr : r_pend_addr;
  assign w_rword = (i_we && (i_waddr == w_raddr)) ? i_wdata : r_mem[w_raddr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_app_ack   <= 1'b0;
      r_app_rdata <= '0;
      r_pio_ack   <= 1'b0;
      r_pio_rdata <= '0;
    end else begin
      r_app_ack <= i_app_rd;
      // Words not yet zeroed by the init sweep are undefined, so INIT reads return 0.
      if (i_app_rd) begin
        r_app_rdata <= i_init ? '0 : w_rword;
      end
      r_pio_ack <= w_svc;
      if (w_svc) begin
        r_pio_rdata <= w_rword;
        r_pend      <= 1'b0;
      end else if (i_pio_set) begin
        r_pend      <= 1'b1;
        r_pend_addr <= i_pio_raddr;
      end
    end
  end

  assign o_app_ack   = r_app_ack;
  assign o_app_rdata = r_app_rdata;
  assign o_pend      = r_pend;
  assign o_pio_ack   = r_pio_ack;
  assign o_pio_rdata = r_pio_rdata;

endmodule
`default_nettype wire

// File: rtl/tm_sch_pri_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tm_sch_pri_mem_bank                                          |
// | Description : NCH priority-scheduler control memories with init sweep      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tm_sch_pri_mem_bank
  import tm_sch_pri_mem_bank_pkg::*;
#(
  parameter int NCH         = c_nch_def,
  parameter int WIDTH       = 2 * c_second_lvl_queue_id_nbits,
  parameter int DEPTH_NBITS = c_second_lvl_sch_id_nbits,
  parameter int PIO_W       = c_pio_w_def
) (
  input  logic                 clk,
  input  logic                 rst,
  tm_sch_pri_mem_bank_if.slave bus
);

  state_e                 r_state;
  logic [DEPTH_NBITS-1:0] r_cnt;
  logic                   r_init_done;
  logic                   r_err;

  logic                   r_wr_vld;
  logic [NCH-1:0]         r_wr_ms;
  logic [DEPTH_NBITS-1:0] r_wr_addr;
  logic [WIDTH-1:0]       r_wr_data;
  logic                   r_zero_ack;

  logic                   w_init;
  logic                   w_rd_acc;
  logic [DEPTH_NBITS-1:0] w_reg_waddr;
  logic [DEPTH_NBITS-1:0] w_waddr;
  logic [WIDTH-1:0]       w_wdata;
  logic [NCH-1:0]         w_chan_we;
  logic [NCH-1:0]         w_pio_set;
  logic [NCH-1:0]         w_pend;
  logic [NCH-1:0]         w_pio_ack;
  logic [NCH-1:0]         w_app_ack;
  logic [WIDTH-1:0]       w_pio_rdata [NCH];
  logic [WIDTH-1:0]       w_app_rdata [NCH];
  logic [WIDTH-1:0]       w_mem_rdata;
  logic [NCH*WIDTH-1:0]   w_app_rdata_flat;
  logic                   w_unused_bits;

  assign w_init      = (r_state == ST_INIT);
  assign w_reg_waddr = bus.reg_addr[DEPTH_NBITS+c_word_lsb-1:c_word_lsb];

  // One PIO read outstanding bus-wide: a new strobe is dropped while any channel holds one.
  assign w_rd_acc  = bus.reg_rd & ~(|w_pend);
  assign w_pio_set = {NCH{w_rd_acc}} & bus.reg_ms;

  assign w_waddr   = w_init ? r_cnt : r_wr_addr;
  assign w_wdata   = w_init ? '0 : r_wr_data;
  assign w_chan_we = {NCH{w_init}} | ({NCH{r_wr_vld}} & r_wr_ms);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_vld   <= 1'b0;
      r_wr_ms    <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_zero_ack <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_vld   <= bus.reg_wr & ~w_init;
      r_wr_ms    <= bus.reg_ms;
      r_wr_addr  <= w_reg_waddr;
      r_wr_data  <= bus.reg_din[WIDTH-1:0];
      r_zero_ack <= w_rd_acc & ~(|bus.reg_ms);
      if (bus.reg_wr && w_init) begin
        r_err <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      tm_sch_pri_mem_chan #(
        .WIDTH       (WIDTH),
        .DEPTH_NBITS (DEPTH_NBITS)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .i_init      (w_init),
        .i_we        (w_chan_we[i]),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_app_rd    (bus.app_rd[i]),
        .i_app_raddr (bus.app_raddr[i*DEPTH_NBITS +: DEPTH_NBITS]),
        .o_app_ack   (w_app_ack[i]),
        .o_app_rdata (w_app_rdata[i]),
        .i_pio_set   (w_pio_set[i]),
        .i_pio_raddr (w_reg_waddr),
        .o_pend      (w_pend[i]),
        .o_pio_ack   (w_pio_ack[i]),
        .o_pio_rdata (w_pio_rdata[i])
      );
    end
  endgenerate

  always_comb begin
    w_mem_rdata      = '0;
    w_app_rdata_flat = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_pio_ack[i]) begin
        w_mem_rdata = w_mem_rdata | w_pio_rdata[i];
      end
      w_app_rdata_flat[i*WIDTH +: WIDTH] = w_app_rdata[i];
    end
  end

  assign w_unused_bits = ^{bus.reg_addr, bus.reg_din};

  assign bus.app_ack            = w_app_ack;
  assign bus.app_rdata          = w_app_rdata_flat;
  assign bus.mem_ack            = r_zero_ack | (|w_pio_ack);
  assign bus.mem_rdata          = PIO_W'(w_mem_rdata);
  assign bus.init_done          = r_init_done;
  assign bus.err_wr_during_init = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tm_sch_pri_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tm_sch_pri_mem_bank                                       |
// | Description : Directed self-checking bench for the scheduler memory bank   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_tm_sch_pri_mem_bank;

  localparam int NCH         = 8;
  localparam int WIDTH       = 12;
  localparam int DEPTH_NBITS = 4;
  localparam int PIO_W       = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  tm_sch_pri_mem_bank_if #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .PIO_W(PIO_W)
  ) bus ();

  tm_sch_pri_mem_bank #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .PIO_W(PIO_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.reg_addr  = '0;
    bus.reg_din   = '0;
    bus.reg_rd    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_ms    = '0;
    bus.app_rd    = '0;
    bus.app_raddr = '0;
  endtask

  // Issues a one-cycle PIO read (optionally with a write in the same cycle) and
  // returns the number of cycles until mem_ack, or -1 if none arrived.
  task automatic pio_read(input logic [7:0] ms, input logic [31:0] addr,
                          input logic wr, input logic [31:0] din,
                          output int lat, output logic [31:0] data);
    bus.reg_rd   = 1'b1;
    bus.reg_wr   = wr;
    bus.reg_ms   = ms;
    bus.reg_addr = addr;
    bus.reg_din  = din;
    step();
    bus.reg_rd = 1'b0;
    bus.reg_wr = 1'b0;
    bus.reg_ms = '0;
    lat  = -1;
    data = '0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.mem_ack) begin
        lat  = k;
        data = bus.mem_rdata;
        break;
      end
      step();
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] data;
    int          acks;

    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    step();
    step();

    check("rst_app_ack",   32'(bus.app_ack), 32'h0);
    check("rst_app_rdata", 32'(|bus.app_rdata), 32'h0);
    check("rst_mem_ack",   32'(bus.mem_ack), 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    check("rst_init_done", 32'(bus.init_done), 32'h0);
    check("rst_err",       32'(bus.err_wr_during_init), 32'h0);

    // Init sweep with an app read at cycle 2 and an illegal write at cycle 4.
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      if (c == 2) begin
        bus.app_rd    = 8'h08;
        bus.app_raddr = {8{4'd5}};
      end
      if (c == 4) begin
        bus.reg_wr   = 1'b1;
        bus.reg_ms   = 8'h01;
        bus.reg_addr = 32'h14;
        bus.reg_din  = 32'h7FF;
      end
      step();
      if (c == 2) begin
        check("init_app_ack",   32'(bus.app_ack), 32'h08);
        check("init_app_rdata", 32'(bus.app_rdata[3*WIDTH +: WIDTH]), 32'h0);
      end
      if (c == 14) check("init_done_c15", 32'(bus.init_done), 32'h0);
      if (c == 15) check("init_done_c16", 32'(bus.init_done), 32'h1);
    end
    idle_inputs();
    check("err_set", 32'(bus.err_wr_during_init), 32'h1);

    pio_read(8'h01, 32'h14, 1'b0, 32'h0, lat, data);
    check("rb_init_lat",  32'(lat), 32'd2);
    check("rb_init_data", data, 32'h0);
    check("err_sticky",   32'(bus.err_wr_during_init), 32'h1);

    // Write then app read on the very next cycle: forwarded value.
    bus.reg_wr   = 1'b1;
    bus.reg_ms   = 8'h04;
    bus.reg_addr = 32'h14;
    bus.reg_din  = 32'h3A7;
    step();
    bus.reg_wr    = 1'b0;
    bus.reg_ms    = '0;
    bus.app_rd    = 8'h04;
    bus.app_raddr = {8{4'd5}};
    step();
    check("fwd_ack",   32'(bus.app_ack), 32'h04);
    check("fwd_rdata", 32'(bus.app_rdata[2*WIDTH +: WIDTH]), 32'h3A7);
    bus.app_rd = '0;
    step();
    check("hold_ack",   32'(bus.app_ack), 32'h0);
    check("hold_rdata", 32'(bus.app_rdata[2*WIDTH +: WIDTH]), 32'h3A7);

    // PIO write and PIO read to the same word in the same cycle.
    pio_read(8'h20, 32'h08, 1'b1, 32'h5C3, lat, data);
    check("wr_rd_lat",  32'(lat), 32'd2);
    check("wr_rd_data", data, 32'h5C3);
    step();

    // Arbitration: app reads on channel 1 starve the pending PIO read.
    bus.reg_wr   = 1'b1;
    bus.reg_ms   = 8'h02;
    bus.reg_addr = 32'h0C;
    bus.reg_din  = 32'h2B5;
    step();
    idle_inputs();
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      bus.app_rd    = 8'h02;
      bus.app_raddr = {8{4'd3}};
      if (c == 0 || c == 4) begin
        bus.reg_rd   = 1'b1;
        bus.reg_ms   = 8'h02;
        bus.reg_addr = (c == 0) ? 32'h0C : 32'h04;
      end
      step();
      acks += int'(bus.mem_ack);
    end
    check("arb_no_early_ack", 32'(acks), 32'd0);
    check("arb_app_rdata", 32'(bus.app_rdata[1*WIDTH +: WIDTH]), 32'h2B5);
    idle_inputs();
    step();
    check("arb_ack",   32'(bus.mem_ack), 32'h1);
    check("arb_rdata", bus.mem_rdata, 32'h2B5);
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      acks += int'(bus.mem_ack);
    end
    check("arb_second_ignored", 32'(acks), 32'd0);

    // Channel isolation: distinct values to word 7 of every channel.
    for (int i = 0; i < NCH; i++) begin
      bus.reg_wr   = 1'b1;
      bus.reg_ms   = 8'(1 << i);
      bus.reg_addr = 32'h1C;
      bus.reg_din  = 32'(8'h11 * (i + 1));
      step();
    end
    idle_inputs();
    bus.app_rd    = 8'hFF;
    bus.app_raddr = {8{4'd7}};
    step();
    check("iso_ack", 32'(bus.app_ack), 32'hFF);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("iso_ch%0d", i), 32'(bus.app_rdata[i*WIDTH +: WIDTH]), 32'(8'h11 * (i + 1)));
    end
    idle_inputs();
    step();

    pio_read(8'h00, 32'h1C, 1'b0, 32'h0, lat, data);
    check("ms0_lat",  32'(lat), 32'd1);
    check("ms0_data", data, 32'h0);
    step();

    // Reset with a PIO read held pending on channel 4.
    bus.app_rd    = 8'h10;
    bus.app_raddr = {8{4'd7}};
    bus.reg_rd    = 1'b1;
    bus.reg_ms    = 8'h10;
    bus.reg_addr  = 32'h1C;
    step();
    bus.reg_rd = 1'b0;
    bus.reg_ms = '0;
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("mrst_init_done", 32'(bus.init_done), 32'h0);
    check("mrst_mem_ack",   32'(bus.mem_ack), 32'h0);
    acks = 0;
    step();
    acks += int'(bus.mem_ack);
    step();
    acks += int'(bus.mem_ack);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      acks += int'(bus.mem_ack);
      if (c == 14) check("mrst_done_c15", 32'(bus.init_done), 32'h0);
      if (c == 15) check("mrst_done_c16", 32'(bus.init_done), 32'h1);
    end
    check("mrst_no_ack", 32'(acks), 32'd0);

    // Every word of every channel reads zero after the new sweep.
    acks = 0;
    for (int a = 0; a < 16; a++) begin
      bus.app_rd    = 8'hFF;
      bus.app_raddr = {8{4'(a)}};
      step();
      if (bus.app_ack !== 8'hFF) acks++;
      check($sformatf("rezero_w%0d", a), 32'(|bus.app_rdata), 32'h0);
    end
    check("rezero_acks_missing", 32'(acks), 32'd0);
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
